// File: rtl/prbs_link_pkg.sv
// Shared types and helpers for the PRBS link bring-up / BER sequencer.
// Contents:
//   state_e    - sequencer state encoding
//   ERR_BITS_W - width of the per-word error count from the PRBS checker
//   CNT_W      - width of the exported error / word totals
//   sat_add    - unsigned add that clamps at all-ones instead of wrapping
package prbs_link_pkg;

  localparam int unsigned ERR_BITS_W = 6;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [2:0] {
    StIdle,
    StResetAlign,
    StWaitAlign,
    StSettle,
    StMeasure,
    StRetry,
    StDone,
    StFail
  } state_e;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/prbs_err_accum.sv
// Saturating bit-error and word accumulators for one measurement window.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clr         - zero both totals (wins over en)
//   en          - count this word: word_total += 1, err_total += err_bits
//   err_bits    - bit errors in the current word
//   err_total   - accumulated bit errors, saturating
//   word_total  - accumulated words, saturating
//   err_next    - err_total after adding this cycle's err_bits (for threshold checks)
//   last_word   - en is high and this word completes the window
module prbs_err_accum
  import prbs_link_pkg::*;
#(
  parameter int unsigned WINDOW_WORDS = 1048576
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [ERR_BITS_W-1:0] err_bits,
  output logic [CNT_W-1:0]      err_total,
  output logic [CNT_W-1:0]      word_total,
  output logic [CNT_W-1:0]      err_next,
  output logic                  last_word
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WINDOW_WORDS - 1);
  localparam logic [CNT_W-1:0] One     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] err_q, words_q;

  always_comb begin
    err_next  = sat_add(err_q, CNT_W'(err_bits));
    last_word = en && (words_q == LastIdx);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      err_q   <= '0;
      words_q <= '0;
    end else if (en) begin
      err_q   <= err_next;
      words_q <= sat_add(words_q, One);
    end
  end

  assign err_total  = err_q;
  assign word_total = words_q;

endmodule

// File: rtl/prbs_link_ctrl.sv
// Bring-up and BER-measurement sequencer for the GTX PRBS loopback link (rxusrclk2 domain).
// Pulses the frame aligner reset, waits for lock, requires lock through a settle period,
// then counts checker-reported bit errors over a fixed word window. Lock loss or align
// timeout retries the whole sequence up to MAX_RETRY times.
// Build option: define PRBS_LINK_CTRL_ERR_LIMIT_EN to abort a measurement straight to FAIL
// once err_total reaches ERR_LIMIT.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   start        - 1-cycle pulse, starts a run from IDLE/DONE/FAIL
//   abort        - level, returns to IDLE (counters retained)
//   aligned      - lock flag from the frame aligner
//   err_valid    - checker word strobe; err_bits = bit errors in that word
//   align_reset  - frame aligner reset
//   busy         - run in progress
//   link_up      - measuring or done
//   done / fail  - window completed / retries exhausted (or error limit hit)
//   retry_cnt    - retries consumed in this run
//   err_total    - accumulated bit errors (saturating)
//   word_total   - words counted in the window
module prbs_link_ctrl
  import prbs_link_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned ALIGN_TIMEOUT = 4096,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned WINDOW_WORDS  = 1048576,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned ERR_LIMIT     = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  aligned,
  input  logic                  err_valid,
  input  logic [ERR_BITS_W-1:0] err_bits,
  output logic                  align_reset,
  output logic                  busy,
  output logic                  link_up,
  output logic                  done,
  output logic                  fail,
  output logic [3:0]            retry_cnt,
  output logic [CNT_W-1:0]      err_total,
  output logic [CNT_W-1:0]      word_total
);

  localparam int unsigned TmrMax0 = (RST_CYCLES > ALIGN_TIMEOUT) ? RST_CYCLES : ALIGN_TIMEOUT;
  localparam int unsigned TmrMax  = (TmrMax0 > SETTLE_CYCLES) ? TmrMax0 : SETTLE_CYCLES;
  localparam int unsigned TmrW    = (TmrMax > 1) ? $clog2(TmrMax) : 1;

  localparam logic [TmrW-1:0] RstLast    = TmrW'(RST_CYCLES - 1);
  localparam logic [TmrW-1:0] WaitLast   = TmrW'(ALIGN_TIMEOUT - 1);
  localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      MaxRetry   = 4'(MAX_RETRY);

  state_e            state_q, state_d;
  logic [TmrW-1:0]   timer_q;
  logic              timer_run;
  logic [3:0]        retry_q, retry_d;
  logic              acc_clr, acc_en, last_word, limit_hit;
  logic [CNT_W-1:0]  err_next;
  logic              align_reset_d, busy_d, link_up_d, done_d, fail_d;

  // Abort drops the word on the abort cycle so the retained totals are stable.
  assign acc_en = (state_q == StMeasure) && err_valid && !abort;

`ifdef PRBS_LINK_CTRL_ERR_LIMIT_EN
  assign limit_hit = acc_en && (err_next >= CNT_W'(ERR_LIMIT));
`else
  logic unused_err_limit;
  assign unused_err_limit = ^{err_next, 32'(ERR_LIMIT)};
  assign limit_hit        = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StFail: if (start) state_d = StResetAlign;
      StResetAlign:           if (timer_q == RstLast) state_d = StWaitAlign;
      StWaitAlign: begin
        if (aligned)                    state_d = StSettle;
        else if (timer_q == WaitLast)   state_d = StRetry;
      end
      StSettle: begin
        if (!aligned)                   state_d = StRetry;
        else if (timer_q == SettleLast) state_d = StMeasure;
      end
      StMeasure: begin
        // The final word is counted even if lock drops on the same cycle.
        if (limit_hit)      state_d = StFail;
        else if (last_word) state_d = StDone;
        else if (!aligned)  state_d = StRetry;
      end
      StRetry:  state_d = (retry_q < MaxRetry) ? StResetAlign : StFail;
      default:  state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // Retry counter clears on a new run and bumps on every re-attempt.
  always_comb begin
    retry_d = retry_q;
    if (state_d == StResetAlign && state_q != StResetAlign) begin
      retry_d = (state_q == StRetry) ? retry_q + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    acc_clr = (state_d == StMeasure && state_q != StMeasure) ||
              (state_d == StResetAlign &&
               (state_q == StIdle || state_q == StDone || state_q == StFail));
    timer_run = (state_q == StResetAlign) || (state_q == StWaitAlign) ||
                (state_q == StSettle);
  end

  // Outputs are decoded from the next state and registered with it.
  always_comb begin
    align_reset_d = (state_d == StResetAlign);
    busy_d        = !((state_d == StIdle) || (state_d == StDone) || (state_d == StFail));
    link_up_d     = (state_d == StMeasure) || (state_d == StDone);
    done_d        = (state_d == StDone);
    fail_d        = (state_d == StFail);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      retry_q     <= '0;
      align_reset <= 1'b0;
      busy        <= 1'b0;
      link_up     <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      align_reset <= align_reset_d;
      busy        <= busy_d;
      link_up     <= link_up_d;
      done        <= done_d;
      fail        <= fail_d;
      if (state_d != state_q) timer_q <= '0;
      else if (timer_run)     timer_q <= timer_q + TmrW'(1);
    end
  end

  assign retry_cnt = retry_q;

  prbs_err_accum #(
    .WINDOW_WORDS (WINDOW_WORDS)
  ) u_accum (
    .clk        (clk),
    .reset      (reset),
    .clr        (acc_clr),
    .en         (acc_en),
    .err_bits   (err_bits),
    .err_total  (err_total),
    .word_total (word_total),
    .err_next   (err_next),
    .last_word  (last_word)
  );

endmodule

// File: tb/tb_prbs_link_ctrl.sv
module tb_prbs_link_ctrl;
  import prbs_link_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, aligned = 1'b0, err_valid = 1'b0;
  logic [5:0] err_bits = '0;
  logic align_reset, busy, link_up, done, fail;
  logic [3:0] retry_cnt;
  logic [31:0] err_total, word_total;

  always #5 clk = ~clk;

  prbs_link_ctrl #(
    .RST_CYCLES    (4),
    .ALIGN_TIMEOUT (32),
    .SETTLE_CYCLES (8),
    .WINDOW_WORDS  (16),
    .MAX_RETRY     (2),
    .ERR_LIMIT     (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .aligned     (aligned),
    .err_valid   (err_valid),
    .err_bits    (err_bits),
    .align_reset (align_reset),
    .busy        (busy),
    .link_up     (link_up),
    .done        (done),
    .fail        (fail),
    .retry_cnt   (retry_cnt),
    .err_total   (err_total),
    .word_total  (word_total)
  );

  typedef struct {
    int          tag;
    logic        done, fail, link_up, busy, align_reset;
    logic [3:0]  retry;
    logic [31:0] err, words;
    int          pulses, width, gap;
    bit          chk_gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic snap_req = 1'b0;
  logic trk_clr  = 1'b0;

  // align_reset pulse tracker: pulse count, last width, low cycles between pulses
  int   pulses = 0, width = 0, gap = 0, low_run = 0;
  logic ar_prev = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (trk_clr) begin
        pulses = 0; width = 0; gap = 0; low_run = 0;
      end else if (align_reset) begin
        if (!ar_prev) begin
          if (pulses > 0) gap = low_run;
          pulses++;
          width = 0;
        end
        width++;
      end else begin
        if (ar_prev) low_run = 0;
        low_run++;
      end
      ar_prev = align_reset;
    end
  end

  function automatic string tag_name(input int t);
    case (t)
      0: return "reset_state";
      1: return "clean_run";
      2: return "errors_counted";
      3: return "timeout_exhaust";
      4: return "lock_loss";
      5: return "abort_settle";
      6: return "start_abort";
      7: return "abort_measure";
      8: return "reset_measure";
      default: return "err_limit";
    endcase
  endfunction

  function automatic exp_t mk(input int tag, input logic d, input logic f, input logic lu,
                              input logic by, input logic ar, input logic [3:0] rc,
                              input logic [31:0] et, input logic [31:0] wt, input int np,
                              input int w, input int g, input bit cg);
    exp_t e;
    e.tag = tag; e.done = d; e.fail = f; e.link_up = lu; e.busy = by; e.align_reset = ar;
    e.retry = rc; e.err = et; e.words = wt; e.pulses = np; e.width = w; e.gap = g;
    e.chk_gap = cg;
    return e;
  endfunction

  task automatic chk(input int tag, input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %0d, expected %0d", tag_name(tag), nm, act, req);
  endtask

  // Monitor: compares the oldest expectation whenever done/fail rises or a snapshot is asked.
  logic done_p = 1'b0, fail_p = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((done && !done_p) || (fail && !fail_p) || snap_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: done=%0b fail=%0b with no expectation queued",
                   done, fail);
        end else begin
          e = exp_q.pop_front();
          chk(e.tag, "done", 32'(done), 32'(e.done));
          chk(e.tag, "fail", 32'(fail), 32'(e.fail));
          chk(e.tag, "link_up", 32'(link_up), 32'(e.link_up));
          chk(e.tag, "busy", 32'(busy), 32'(e.busy));
          chk(e.tag, "align_reset", 32'(align_reset), 32'(e.align_reset));
          chk(e.tag, "retry_cnt", 32'(retry_cnt), 32'(e.retry));
          chk(e.tag, "err_total", err_total, e.err);
          chk(e.tag, "word_total", word_total, e.words);
          chk(e.tag, "align_pulses", 32'(pulses), 32'(e.pulses));
          chk(e.tag, "align_width", 32'(width), 32'(e.width));
          if (e.chk_gap) chk(e.tag, "align_gap", 32'(gap), 32'(e.gap));
        end
      end
      done_p = done;
      fail_p = fail;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic sig_val(input int which);
    case (which)
      0: return align_reset;
      1: return link_up;
      default: return done | fail;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic level, input int budget,
                          input string what);
    bit hit = 0;
    for (int i = 0; i < budget; i++) begin
      if (sig_val(which) == level) begin
        hit = 1;
        break;
      end
      tick(1);
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL timeout_%s: still not %0b after %0d cycles", what, level, budget);
    end
  endtask

  task automatic begin_run();
    trk_clr = 1'b1;
    tick(1);
    trk_clr = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Waits through the align_reset pulse, raises lock after dly cycles, waits for MEASURE.
  task automatic lock_after(input int dly);
    wait_sig(0, 1'b1, 10, "align_reset_rise");
    wait_sig(0, 1'b0, 20, "align_reset_fall");
    tick(dly);
    aligned = 1'b1;
    wait_sig(1, 1'b1, 40, "link_up");
  endtask

  task automatic send_word(input logic [5:0] b);
    err_valid = 1'b1;
    err_bits  = b;
    tick(1);
    err_valid = 1'b0;
    err_bits  = '0;
  endtask

  task automatic snap();
    snap_req = 1'b1;
    tick(1);
    snap_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat[16];
    tick(3);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0));
    snap();
    reset = 1'b0;
    tick(2);

    // Clean run: zero errors over 16 words.
    exp_q.push_back(mk(1, 1, 0, 1, 0, 0, 4'd0, 0, 16, 1, 4, 0, 0));
    begin_run();
    lock_after(5);
    for (int i = 0; i < 16; i++) send_word(6'd0);
    wait_sig(2, 1'b1, 5, "done_clean");
    aligned = 1'b0;
    tick(2);

    // Errors: 1+1+1+2 = 5.
    for (int i = 0; i < 16; i++) pat[i] = 6'd0;
    pat[2] = 6'd1; pat[5] = 6'd1; pat[9] = 6'd1; pat[12] = 6'd2;
    exp_q.push_back(mk(2, 1, 0, 1, 0, 0, 4'd0, 5, 16, 1, 4, 0, 0));
    begin_run();
    lock_after(5);
    for (int i = 0; i < 16; i++) send_word(pat[i]);
    wait_sig(2, 1'b1, 5, "done_errors");
    aligned = 1'b0;
    tick(2);

    // Timeout: 3 attempts, each 32 wait + 1 retry cycle between pulses.
    exp_q.push_back(mk(3, 0, 1, 0, 0, 0, 4'd2, 0, 0, 3, 4, 33, 1));
    begin_run();
    wait_sig(2, 1'b1, 200, "fail_timeout");
    tick(2);

    // Lock loss after 7 words, recover on the retry.
    exp_q.push_back(mk(4, 1, 0, 1, 0, 0, 4'd1, 0, 16, 2, 4, 0, 0));
    begin_run();
    lock_after(5);
    for (int i = 0; i < 7; i++) send_word(6'd1);
    aligned = 1'b0;
    tick(1);
    lock_after(3);
    for (int i = 0; i < 16; i++) send_word(6'd0);
    wait_sig(2, 1'b1, 5, "done_lockloss");
    aligned = 1'b0;
    tick(2);

    // Abort during SETTLE.
    begin_run();
    wait_sig(0, 1'b1, 10, "align_reset_rise");
    wait_sig(0, 1'b0, 20, "align_reset_fall");
    tick(2);
    aligned = 1'b1;
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    aligned = 1'b0;
    exp_q.push_back(mk(5, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1, 4, 0, 0));
    snap();
    tick(1);

    // start and abort together: abort wins, no new pulse.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    exp_q.push_back(mk(6, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1, 4, 0, 0));
    snap();
    tick(1);

    // Abort in MEASURE keeps counters for readout.
    begin_run();
    lock_after(5);
    for (int i = 0; i < 5; i++) send_word(6'd3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    aligned = 1'b0;
    exp_q.push_back(mk(7, 0, 0, 0, 0, 0, 4'd0, 15, 5, 1, 4, 0, 0));
    snap();
    tick(1);

    // Synchronous reset in MEASURE clears everything.
    begin_run();
    lock_after(5);
    for (int i = 0; i < 5; i++) send_word(6'd3);
    reset = 1'b1;
    tick(1);
    exp_q.push_back(mk(8, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1, 4, 0, 0));
    snap();
    reset = 1'b0;
    aligned = 1'b0;
    tick(2);

    // Four errors per word.
`ifdef PRBS_LINK_CTRL_ERR_LIMIT_EN
    exp_q.push_back(mk(9, 0, 1, 0, 0, 0, 4'd0, 12, 3, 1, 4, 0, 0));
`else
    exp_q.push_back(mk(9, 1, 0, 1, 0, 0, 4'd0, 64, 16, 1, 4, 0, 0));
`endif
    begin_run();
    lock_after(5);
    for (int i = 0; i < 16; i++) send_word(6'd4);
    wait_sig(2, 1'b1, 5, "end_errlimit");
    tick(3);

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL pending_expectations: %0d left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
